// File: rtl/vend_pkg.sv
// Shared types and constants for the vending purchase stage: FSM states,
// mode and error encodings, and the coin denomination decode.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } state_e;

    localparam logic [1:0] MODE_CHARGE   = 2'b01;
    localparam logic [1:0] MODE_PURCHASE = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_SEL  = 2'b01;
    localparam logic [1:0] ERR_SOLD_OUT = 2'b10;
    localparam logic [1:0] ERR_FUNDS    = 2'b11;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   return 8'd1;
            2'b01:   return 8'd2;
            2'b10:   return 8'd5;
            default: return 8'd10;
        endcase
    endfunction

endpackage

// File: rtl/vend_slot_mux.sv
// Combinational slot access: extracts stock and price for a 1-based slot index
// and builds the inventory word with that slot's stock decremented.
module vend_slot_mux #(
    parameter int NUM_GOODS = 5,
    parameter int CNT_W     = 4,
    parameter int PRICE_W   = 8
) (
    input  logic [NUM_GOODS*CNT_W-1:0]   inv_i,
    input  logic [NUM_GOODS*PRICE_W-1:0] price_all_i,
    input  logic [2:0]                   idx_i,
    output logic                         hit_o,
    output logic [CNT_W-1:0]             stock_o,
    output logic [PRICE_W-1:0]           price_o,
    output logic [NUM_GOODS*CNT_W-1:0]   inv_dec_o
);

    // Index 0 and indices above NUM_GOODS match no slot, so hit_o stays low.
    always_comb begin
        hit_o     = 1'b0;
        stock_o   = '0;
        price_o   = '0;
        inv_dec_o = inv_i;
        for (int k = 0; k < NUM_GOODS; k++) begin
            if (idx_i == 3'(k + 1)) begin
                hit_o   = 1'b1;
                stock_o = inv_i[k*CNT_W +: CNT_W];
                price_o = price_all_i[k*PRICE_W +: PRICE_W];
                inv_dec_o[k*CNT_W +: CNT_W] = inv_i[k*CNT_W +: CNT_W] - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vend_purchase.sv
// Customer-side purchase stage: accumulates coin credit, validates a selection
// against stock and price, writes back decremented inventory, dispenses and returns change.
module vend_purchase
    import vend_pkg::*;
#(
    parameter int NUM_GOODS   = 5,
    parameter int CNT_W       = 4,
    parameter int PRICE_W     = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   mode_i,
    input  logic                         coin_valid_i,
    input  logic [1:0]                   coin_val_i,
    input  logic                         select_valid_i,
    input  logic [2:0]                   select_idx_i,
    input  logic                         cancel_i,
    input  logic [NUM_GOODS*CNT_W-1:0]   inv_in_i,
    input  logic [NUM_GOODS*PRICE_W-1:0] price_all_i,
    input  logic                         dispense_ready_i,
    input  logic                         change_ready_i,
    output logic [NUM_GOODS*CNT_W-1:0]   inv_out_o,
    output logic                         inv_we_o,
    output logic [PRICE_W-1:0]           credit_o,
    output logic                         coin_reject_o,
    output logic                         dispense_valid_o,
    output logic [2:0]                   dispense_idx_o,
    output logic                         change_valid_o,
    output logic [PRICE_W-1:0]           change_amt_o,
    output logic                         error_o,
    output logic [1:0]                   err_code_o,
    output logic                         busy_o,
    output logic [2:0]                   dbg_state_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    state_e                       state_q, state_d;
    logic [PRICE_W-1:0]           credit_q, credit_d;
    logic [2:0]                   idx_q, idx_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [1:0]                   err_code_q, err_code_d;
    logic                         error_q, error_d;
    logic                         coin_reject_q, coin_reject_d;
    logic                         inv_we_q, inv_we_d;
    logic [NUM_GOODS*CNT_W-1:0]   inv_out_q, inv_out_d;

    logic                         slot_hit;
    logic [CNT_W-1:0]             slot_stock;
    logic [PRICE_W-1:0]           slot_price;
    logic [NUM_GOODS*CNT_W-1:0]   inv_dec;
    logic [PRICE_W:0]             coin_sum;
    logic [PRICE_W-1:0]           credit_after_coin;

    vend_slot_mux #(
        .NUM_GOODS (NUM_GOODS),
        .CNT_W     (CNT_W),
        .PRICE_W   (PRICE_W)
    ) u_slot_mux (
        .inv_i       (inv_in_i),
        .price_all_i (price_all_i),
        .idx_i       (idx_q),
        .hit_o       (slot_hit),
        .stock_o     (slot_stock),
        .price_o     (slot_price),
        .inv_dec_o   (inv_dec)
    );

    assign coin_sum = {1'b0, credit_q} + {1'b0, PRICE_W'(coin_value(coin_val_i))};

    always_comb begin
        state_d           = state_q;
        credit_d          = credit_q;
        idx_d             = idx_q;
        tmo_d             = '0;
        err_code_d        = err_code_q;
        error_d           = 1'b0;
        coin_reject_d     = 1'b0;
        inv_we_d          = 1'b0;
        inv_out_d         = inv_out_q;
        credit_after_coin = credit_q;

        case (state_q)
            ST_IDLE: begin
                if (coin_valid_i && mode_i == MODE_PURCHASE) begin
                    credit_d = PRICE_W'(coin_value(coin_val_i));
                    state_d  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                tmo_d = tmo_q + 1'b1;
                // A coin in the same cycle as cancel/select is credited first.
                if (coin_valid_i) begin
                    tmo_d = '0;
                    if (coin_sum[PRICE_W]) coin_reject_d = 1'b1;
                    else credit_after_coin = coin_sum[PRICE_W-1:0];
                end
                credit_d = credit_after_coin;
                if (cancel_i) begin
                    state_d = (credit_after_coin != '0) ? ST_CHANGE : ST_IDLE;
                end else if (select_valid_i) begin
                    idx_d   = select_idx_i;
                    tmo_d   = '0;
                    state_d = ST_CHECK;
                end else if (!coin_valid_i && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = (credit_after_coin != '0) ? ST_CHANGE : ST_IDLE;
                end
                if (state_d != ST_CREDIT) tmo_d = '0;
            end
            ST_CHECK: begin
                if (!slot_hit) begin
                    err_code_d = ERR_BAD_SEL;
                end else if (slot_stock == '0) begin
                    err_code_d = ERR_SOLD_OUT;
                end else if (credit_q < slot_price) begin
                    err_code_d = ERR_FUNDS;
                end
                if (!slot_hit || slot_stock == '0 || credit_q < slot_price) begin
                    error_d = 1'b1;
                    state_d = ST_CREDIT;
                end else begin
                    credit_d  = credit_q - slot_price;
                    inv_out_d = inv_dec;
                    inv_we_d  = 1'b1;
                    state_d   = ST_DISPENSE;
                end
            end
            // Dispense and change use valid/ready: the request is held stable
            // until ready is seen high on a rising edge, which completes the transfer.
            ST_DISPENSE: begin
                if (dispense_ready_i) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (change_ready_i) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) err_code_d = ERR_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            err_code_q    <= ERR_NONE;
            error_q       <= 1'b0;
            coin_reject_q <= 1'b0;
            inv_we_q      <= 1'b0;
            inv_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            err_code_q    <= err_code_d;
            error_q       <= error_d;
            coin_reject_q <= coin_reject_d;
            inv_we_q      <= inv_we_d;
            inv_out_q     <= inv_out_d;
        end
    end

    assign dispense_valid_o = (state_q == ST_DISPENSE);
    assign dispense_idx_o   = dispense_valid_o ? idx_q : 3'd0;
    assign change_valid_o   = (state_q == ST_CHANGE);
    assign change_amt_o     = change_valid_o ? credit_q : '0;
    assign inv_out_o        = inv_out_q;
    assign inv_we_o         = inv_we_q;
    assign credit_o         = credit_q;
    assign coin_reject_o    = coin_reject_q;
    assign error_o          = error_q;
    assign err_code_o       = err_code_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_vend_purchase.sv
// Self-checking bench for vend_purchase: table of selection vectors plus
// hand-written sequences for overflow, coin+cancel, timeout and mid-dispense reset.
module tb_vend_purchase;
    import vend_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode_i;
    logic        coin_valid_i;
    logic [1:0]  coin_val_i;
    logic        select_valid_i;
    logic [2:0]  select_idx_i;
    logic        cancel_i;
    logic [19:0] inv_in_i;
    logic [39:0] price_all_i;
    logic        dispense_ready_i;
    logic        change_ready_i;
    logic [19:0] inv_out_o;
    logic        inv_we_o;
    logic [7:0]  credit_o;
    logic        coin_reject_o;
    logic        dispense_valid_o;
    logic [2:0]  dispense_idx_o;
    logic        change_valid_o;
    logic [7:0]  change_amt_o;
    logic        error_o;
    logic [1:0]  err_code_o;
    logic        busy_o;
    logic [2:0]  dbg_state_o;

    always #5 clk = ~clk;

    vend_purchase dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mode_i           (mode_i),
        .coin_valid_i     (coin_valid_i),
        .coin_val_i       (coin_val_i),
        .select_valid_i   (select_valid_i),
        .select_idx_i     (select_idx_i),
        .cancel_i         (cancel_i),
        .inv_in_i         (inv_in_i),
        .price_all_i      (price_all_i),
        .dispense_ready_i (dispense_ready_i),
        .change_ready_i   (change_ready_i),
        .inv_out_o        (inv_out_o),
        .inv_we_o         (inv_we_o),
        .credit_o         (credit_o),
        .coin_reject_o    (coin_reject_o),
        .dispense_valid_o (dispense_valid_o),
        .dispense_idx_o   (dispense_idx_o),
        .change_valid_o   (change_valid_o),
        .change_amt_o     (change_amt_o),
        .error_o          (error_o),
        .err_code_o       (err_code_o),
        .busy_o           (busy_o),
        .dbg_state_o      (dbg_state_o)
    );

    typedef struct {
        int          va;
        int          vb;
        logic [2:0]  sel;
        logic        exp_we;
        logic [1:0]  exp_err;
        logic [7:0]  exp_credit;
        logic [19:0] exp_inv;
    } vec_t;

    vec_t        vecs[11];
    logic [19:0] inv_exp_q[$];
    logic [2:0]  disp_exp_q[$];
    logic [7:0]  chg_exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic        prev_disp = 1'b0;
    logic        prev_chg = 1'b0;

    function automatic logic [1:0] code_of(input int v);
        case (v)
            1:       return 2'b00;
            2:       return 2'b01;
            5:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic monitor();
        if (inv_we_o) begin
            if (inv_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL inv_we_unexpected: got inv_out %0h expected no write", inv_out_o);
            end else check("sb_inv_out", 32'(inv_out_o), 32'(inv_exp_q.pop_front()));
        end
        if (dispense_valid_o && !prev_disp) begin
            if (disp_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL dispense_unexpected: got idx %0d expected none", dispense_idx_o);
            end else check("sb_dispense_idx", 32'(dispense_idx_o), 32'(disp_exp_q.pop_front()));
        end
        if (change_valid_o && !prev_chg) begin
            if (chg_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL change_unexpected: got amt %0d expected none", change_amt_o);
            end else check("sb_change_amt", 32'(change_amt_o), 32'(chg_exp_q.pop_front()));
        end
        prev_disp = dispense_valid_o;
        prev_chg  = change_valid_o;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic coin(input int v);
        coin_valid_i = 1'b1;
        coin_val_i   = code_of(v);
        tick();
        coin_valid_i = 1'b0;
    endtask

    task automatic do_select(input logic [2:0] idx);
        select_valid_i = 1'b1;
        select_idx_i   = idx;
        tick();
        select_valid_i = 1'b0;
    endtask

    task automatic finish_change();
        change_ready_i = 1'b1;
        tick();
        change_ready_i = 1'b0;
        check("after_change_busy", 32'(busy_o), 32'd0);
        check("after_change_credit", 32'(credit_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {inv_out_o, inv_we_o, coin_reject_o, dispense_valid_o, dispense_idx_o},
              32'd0);
        check({tag, "_credit"}, 32'(credit_o), 32'd0);
        check({tag, "_change"}, {change_valid_o, change_amt_o, error_o, err_code_o, busy_o}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state_o), 32'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n = 1'b0; mode_i = MODE_PURCHASE; coin_valid_i = 1'b0; coin_val_i = 2'b00;
        select_valid_i = 1'b0; select_idx_i = 3'd0; cancel_i = 1'b0;
        dispense_ready_i = 1'b0; change_ready_i = 1'b0;
        // slots 1..5: stock 5,3,1,0,9; price 8,12,20,7,15
        inv_in_i    = 20'h90135;
        price_all_i = 40'h0F_07_14_0C_08;

        vecs[0]  = '{10, 5, 3'd2, 1'b1, 2'b00, 8'd3,  20'h90125};
        vecs[1]  = '{5,  0, 3'd1, 1'b0, 2'b11, 8'd5,  20'h0};
        vecs[2]  = '{10, 10, 3'd4, 1'b0, 2'b10, 8'd20, 20'h0};
        vecs[3]  = '{10, 10, 3'd6, 1'b0, 2'b01, 8'd20, 20'h0};
        vecs[4]  = '{10, 10, 3'd3, 1'b1, 2'b00, 8'd0,  20'h90035};
        vecs[5]  = '{10, 2, 3'd5, 1'b0, 2'b11, 8'd12, 20'h0};
        vecs[6]  = '{1,  0, 3'd4, 1'b0, 2'b10, 8'd1,  20'h0};
        vecs[7]  = '{1,  0, 3'd7, 1'b0, 2'b01, 8'd1,  20'h0};
        vecs[8]  = '{10, 0, 3'd1, 1'b1, 2'b00, 8'd2,  20'h90134};
        vecs[9]  = '{1,  0, 3'd0, 1'b0, 2'b01, 8'd1,  20'h0};
        vecs[10] = '{2,  5, 3'd1, 1'b0, 2'b11, 8'd7,  20'h0};

        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Select and cancel in IDLE are ignored; coins outside purchase mode too.
        select_valid_i = 1'b1; select_idx_i = 3'd1; cancel_i = 1'b1;
        tick();
        select_valid_i = 1'b0; cancel_i = 1'b0;
        mode_i = MODE_CHARGE;
        coin(10);
        check("idle_ignore_busy", 32'(busy_o), 32'd0);
        check("idle_ignore_credit", 32'(credit_o), 32'd0);
        mode_i = MODE_PURCHASE;

        for (int i = 0; i < 11; i++) begin
            coin(vecs[i].va);
            if (vecs[i].vb != 0) coin(vecs[i].vb);
            check($sformatf("v%0d_credit_in", i), 32'(credit_o), 32'(vecs[i].va + vecs[i].vb));
            if (vecs[i].exp_we) begin
                inv_exp_q.push_back(vecs[i].exp_inv);
                disp_exp_q.push_back(vecs[i].sel);
                if (vecs[i].exp_credit != 0) chg_exp_q.push_back(vecs[i].exp_credit);
            end
            do_select(vecs[i].sel);
            check($sformatf("v%0d_check_state", i), 32'(dbg_state_o), 32'(ST_CHECK));
            tick();
            check($sformatf("v%0d_error", i), 32'(error_o), 32'(!vecs[i].exp_we));
            check($sformatf("v%0d_err_code", i), 32'(err_code_o), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_inv_we", i), 32'(inv_we_o), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_credit", i), 32'(credit_o), 32'(vecs[i].exp_credit));
            check($sformatf("v%0d_dispense", i), 32'(dispense_valid_o), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                dispense_ready_i = 1'b1;
                tick();
                dispense_ready_i = 1'b0;
                check($sformatf("v%0d_inv_we_pulse", i), 32'(inv_we_o), 32'd0);
                check($sformatf("v%0d_change_valid", i), 32'(change_valid_o),
                      32'(vecs[i].exp_credit != 0));
                if (vecs[i].exp_credit != 0) finish_change();
                else check($sformatf("v%0d_idle", i), 32'(busy_o), 32'd0);
            end else begin
                check($sformatf("v%0d_back_credit", i), 32'(dbg_state_o), 32'(ST_CREDIT));
                chg_exp_q.push_back(vecs[i].exp_credit);
                cancel_i = 1'b1;
                tick();
                cancel_i = 1'b0;
                check($sformatf("v%0d_err_held", i), 32'(err_code_o), 32'(vecs[i].exp_err));
                finish_change();
                check($sformatf("v%0d_err_cleared", i), 32'(err_code_o), 32'd0);
            end
        end

        // Sold-out then bad index within one transaction.
        coin(10); coin(10);
        do_select(3'd4); tick();
        check("seq_soldout_code", 32'(err_code_o), 32'(ERR_SOLD_OUT));
        do_select(3'd6); tick();
        check("seq_badsel_pulse", 32'(error_o), 32'd1);
        check("seq_badsel_code", 32'(err_code_o), 32'(ERR_BAD_SEL));
        tick();
        check("seq_error_one_cycle", 32'(error_o), 32'd0);
        check("seq_err_held", 32'(err_code_o), 32'(ERR_BAD_SEL));
        chg_exp_q.push_back(8'd20);
        cancel_i = 1'b1; tick(); cancel_i = 1'b0;
        finish_change();

        // Overflow boundary: 250 + 10 refused, 250 + 5 = 255 accepted, 255 + 1 refused.
        for (int i = 0; i < 25; i++) coin(10);
        check("ovf_credit_250", 32'(credit_o), 32'd250);
        coin(10);
        check("ovf_reject_pulse", 32'(coin_reject_o), 32'd1);
        check("ovf_credit_kept", 32'(credit_o), 32'd250);
        coin(5);
        check("ovf_reject_low", 32'(coin_reject_o), 32'd0);
        check("ovf_credit_255", 32'(credit_o), 32'd255);
        coin(1);
        check("ovf_reject_255", 32'(coin_reject_o), 32'd1);
        check("ovf_credit_255_kept", 32'(credit_o), 32'd255);
        tick();
        check("ovf_reject_one_cycle", 32'(coin_reject_o), 32'd0);
        chg_exp_q.push_back(8'd255);
        cancel_i = 1'b1; tick(); cancel_i = 1'b0;
        finish_change();

        // Coin and cancel together from credit 7; mode change mid-transaction is ignored.
        coin(5); coin(2);
        mode_i = MODE_CHARGE;
        chg_exp_q.push_back(8'd9);
        coin_valid_i = 1'b1; coin_val_i = code_of(2); cancel_i = 1'b1;
        tick();
        coin_valid_i = 1'b0; cancel_i = 1'b0;
        check("coin_cancel_change", 32'(change_valid_o), 32'd1);
        finish_change();
        mode_i = MODE_PURCHASE;

        // Timeout: change appears exactly TIMEOUT_CYC edges after the last coin.
        coin(2); coin(2);
        chg_exp_q.push_back(8'd4);
        cnt = 0;
        while (!change_valid_o && cnt < 1100) begin
            tick();
            cnt++;
        end
        check("timeout_latency", 32'(cnt), 32'd1000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_%0d", i), {change_valid_o, change_amt_o}, {1'b1, 8'd4});
        end
        finish_change();

        // Reset during DISPENSE; coins/cancel in DISPENSE are ignored beforehand.
        coin(10);
        inv_exp_q.push_back(20'h90134);
        disp_exp_q.push_back(3'd1);
        do_select(3'd1); tick();
        coin_valid_i = 1'b1; coin_val_i = code_of(5); cancel_i = 1'b1;
        tick();
        coin_valid_i = 1'b0; cancel_i = 1'b0;
        check("disp_ignore_state", 32'(dbg_state_o), 32'(ST_DISPENSE));
        check("disp_ignore_credit", 32'(credit_o), 32'd2);
        check("disp_hold_idx", {dispense_valid_o, dispense_idx_o}, {1'b1, 3'd1});
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        mode_i = MODE_CHARGE;
        coin(5);
        check("post_reset_charge_busy", 32'(busy_o), 32'd0);
        check("post_reset_charge_credit", 32'(credit_o), 32'd0);
        tick();

        check("inv_q_empty", 32'(inv_exp_q.size()), 32'd0);
        check("disp_q_empty", 32'(disp_exp_q.size()), 32'd0);
        check("chg_q_empty", 32'(chg_exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
